// File: rtl/var_bw_seq_mul.sv
// Sequential variable-bitwidth shift-add multiplier, MSB-first, one ripple add per cycle.
// Optional build macro MUL_SIGNED_EN: two's-complement operands at the active width n.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module var_bw_seq_mul #(
    parameter int W  = 16,
    parameter int CW = $clog2(W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [CW-1:0]   bw,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  p
);
    localparam int PW = 2 * W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   a_ext, a_r, acc, shifted, addend, sum;
    logic [W-1:0]    b_msk, b_r;
    logic [CW-1:0]   cnt;
    logic [PW:0]     carry;
    logic            bit_sel, cin, unused_cout;

    // Operand conditioning at the accept edge: drop bits above bw, extend a to 2W.
    always_comb begin
        a_ext = '0;
        b_msk = '0;
        for (int i = 0; i < W; i++) begin
            if (i <= int'(bw)) begin
                a_ext[i] = a[i];
                b_msk[i] = b[i];
            end
        end
`ifdef MUL_SIGNED_EN
        for (int i = 0; i < PW; i++) begin
            if (i > int'(bw)) a_ext[i] = a[bw];
        end
`endif
    end

    assign bit_sel = b_r[cnt];
    assign shifted = {acc[PW-2:0], 1'b0};

`ifdef MUL_SIGNED_EN
    logic [CW-1:0] bw_r;
    logic          sub;
    // The sign bit of b carries weight -2^(n-1), so its partial product is subtracted.
    assign sub    = bit_sel && (cnt == bw_r);
    assign addend = bit_sel ? (sub ? ~a_r : a_r) : '0;
    assign cin    = sub;
`else
    assign addend = bit_sel ? a_r : '0;
    assign cin    = 1'b0;
`endif

    assign carry[0] = cin;
    generate
        for (genvar g = 0; g < PW; g++) begin : g_fa
            full_adder u_fa (
                .x  (shifted[g]),
                .y  (addend[g]),
                .ci (carry[g]),
                .s  (sum[g]),
                .co (carry[g+1])
            );
        end
    endgenerate
    // Carry out of the top bit is intentionally dropped (product is mod 2^2W).
    assign unused_cout = carry[PW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
`ifdef MUL_SIGNED_EN
            bw_r <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r  <= a_ext;
                    b_r  <= b_msk;
                    acc  <= '0;
                    cnt  <= bw;
`ifdef MUL_SIGNED_EN
                    bw_r <= bw;
`endif
                end
                RUN: begin
                    acc <= sum;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // acc is frozen outside RUN, so it doubles as the held product register.
    assign p = acc;

endmodule

// File: tb/tb_var_bw_seq_mul.sv
// Bench for var_bw_seq_mul: table vectors plus hand sequences, scoreboard queue of products.
// Honors MUL_SIGNED_EN the same way as the design build.

module tb_var_bw_seq_mul;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a, b;
    logic [3:0]    bw;
    logic [31:0]   p;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [31:0]   sbq[$];
    logic [31:0]   last_p;

    typedef struct {
        logic [3:0]  bw;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    var_bw_seq_mul #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bw(bw), .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] mbw, input logic [15:0] ma, input logic [15:0] mb);
        logic [31:0] ax, bx;
        ax = '0;
        bx = '0;
        for (int i = 0; i < 32; i++) begin
            if (i <= int'(mbw)) begin
                ax[i] = ma[i];
                bx[i] = mb[i];
            end else begin
`ifdef MUL_SIGNED_EN
                ax[i] = ma[mbw];
                bx[i] = mb[mbw];
`endif
            end
        end
        return ax * bx;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue one operand pair at a negedge; afterwards scramble the inputs to prove
    // only the accept edge matters. Returns in DONE (out_ready=0) or back in IDLE.
    task automatic run_txn(input logic [3:0] tbw, input logic [15:0] ta, input logic [15:0] tb_,
                           input string name);
        int  lat;
        bit  got;
        for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            check({name, " ready timeout"}, 32'd0, 32'd1);
            return;
        end
        bw = tbw; a = ta; b = tb_; in_valid = 1'b1;
        sbq.push_back(model(tbw, ta, tb_));
        @(negedge clk);
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); bw = 4'($urandom);
        lat = 1;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!got) begin
            check({name, " out_valid timeout"}, 32'd0, 32'd1);
            void'(sbq.pop_front());
            return;
        end
        check({name, " latency"}, 32'(lat), 32'(int'(tbw) + 2));
        last_p = p;
        check({name, " p"}, p, sbq.pop_front());
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        logic [31:0] e2, e3;
        bit          saw;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bw = '0;
        last_p = '0;

        vecs[0] = '{4'd15, 16'h1234, 16'h5678, 32'd0};
        vecs[1] = '{4'd7,  16'h00FF, 16'h00FF, 32'd0};
        vecs[2] = '{4'd0,  16'hFFFE, 16'hFFFF, 32'd0};
        vecs[3] = '{4'd1,  16'h0003, 16'h0002, 32'd0};
        vecs[4] = '{4'd11, 16'hF800, 16'h0801, 32'd0};
        vecs[5] = '{4'd15, 16'h8000, 16'h8000, 32'd0};
        vecs[6] = '{4'd15, 16'h0000, 16'hBEEF, 32'd0};
        for (int i = 7; i < 10; i++)
            vecs[i] = '{4'($urandom), 16'($urandom), 16'($urandom), 32'd0};
        for (int i = 0; i < 10; i++) vecs[i].exp = model(vecs[i].bw, vecs[i].a, vecs[i].b);

        // reset state
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset p", p, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].bw, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table", i), last_p, vecs[i].exp);
        end

`ifdef MUL_SIGNED_EN
        e2 = 32'h00000001;
        e3 = 32'h0000000F;
`else
        e2 = 32'hFFFE0001;
        e3 = 32'h0000008F;
`endif
        run_txn(4'd15, 16'hFFFF, 16'hFFFF, "full width");
        check("full width const", last_p, e2);
        run_txn(4'd3, 16'hABCD, 16'h123B, "nibble");
        check("nibble const", last_p, e3);

        // bw=0 with downstream stalled: product held, upstream blocked
        out_ready = 1'b0;
        run_txn(4'd0, 16'h0001, 16'h0001, "bw0");
        check("bw0 const", last_p, 32'd1);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0]; a = 16'hFFFF; b = 16'hFFFF; bw = 4'd15;
            @(negedge clk);
            check($sformatf("hold%0d p", k), p, 32'd1);
            check($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release out_valid", 32'(out_valid), 32'd0);
        check("release in_ready", 32'(in_ready), 32'd1);

        // async reset mid-RUN aborts the transaction
        bw = 4'd7; a = 16'd77; b = 16'd55; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst in_ready", 32'(in_ready), 32'd1);
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst p", p, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("abort no out_valid", 32'(saw), 32'd0);
        run_txn(4'd7, 16'd200, 16'd100, "after abort");
`ifndef MUL_SIGNED_EN
        check("after abort const", last_p, 32'd20000);
`else
        check("after abort const", last_p, 32'hFFFFEA20);
        run_txn(4'd7, 16'h00FE, 16'h0003, "signed neg");
        check("signed neg const", last_p, 32'hFFFFFFFA);
        run_txn(4'd7, 16'h0080, 16'h0080, "signed min");
        check("signed min const", last_p, 32'h00004000);
`endif

        check("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
